// File: rtl/game_sequencer.sv
// game_sequencer: start-key synchronizer/edge detect, game FSM, MOVE_EN pacing, score and level tracking.
// Latency: key to START in 3 edges; SQUARE_READY, BLOCK_SHIFT and COLLISION act on the next edge; all outputs registered.
// Backpressure: none; the obstacle controller advances only on MOVE_EN and cannot stall this block.
module game_sequencer #(
  parameter int BASE_PERIOD = 8,
  parameter int PERIOD_STEP = 1,
  parameter int MIN_PERIOD  = 2,
  parameter int LEVEL_STEP  = 10,
  parameter int MAX_LEVEL   = 5,
  parameter int SCORE_MAX   = 999
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_START,
  input  logic       SQUARE_READY,
  input  logic       BLOCK_SHIFT,
  input  logic       COLLISION,
  output logic       START,
  output logic       MOVE_EN,
  output logic       OVER,
  output logic [9:0] SCORE,
  output logic [2:0] LEVEL,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMED     = 2'b01,
    RUN       = 2'b11,
    GAME_OVER = 2'b10
  } state_t;

  state_t      state;
  logic        key_sync1;
  logic        key_sync2;
  logic        key_prev;
  logic [1:0]  sync_fill;
  logic        key_rise;
  logic [7:0]  tick_cnt;
  logic [7:0]  period;
  logic [10:0] reduction;
  logic [9:0]  score_inc;
  logic        score_lvl_up;

  // Synchronize the raw key and remember its previous value. key_prev starts high and only
  // follows the synchronizer once it holds real samples, so a key held through reset release
  // never looks like a fresh press.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      key_sync1 <= 1'b0;
      key_sync2 <= 1'b0;
      key_prev  <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      key_sync1 <= KEY_START;
      key_sync2 <= key_sync1;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1]) begin
        key_prev <= key_sync2;
      end
    end
  end

  assign key_rise = key_sync2 & ~key_prev;

  // Level-dependent MOVE_EN period, floored at MIN_PERIOD without going through a negative value.
  always_comb begin
    reduction = 11'(LEVEL) * 11'(PERIOD_STEP);
    if (reduction + 11'(MIN_PERIOD) >= 11'(BASE_PERIOD)) begin
      period = 8'(MIN_PERIOD);
    end else begin
      period = 8'(11'(BASE_PERIOD) - reduction);
    end
  end

  // Saturating next score and whether that new score earns a level-up.
  always_comb begin
    score_inc    = SCORE;
    score_lvl_up = 1'b0;
    if (SCORE < 10'(SCORE_MAX)) begin
      score_inc    = SCORE + 10'd1;
      score_lvl_up = ((score_inc % 10'(LEVEL_STEP)) == 10'd0);
    end
  end

  // Game FSM with registered START/MOVE_EN pulses, OVER flag, score, level and tick counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      START    <= 1'b0;
      MOVE_EN  <= 1'b0;
      OVER     <= 1'b0;
      SCORE    <= 10'd0;
      LEVEL    <= 3'd0;
      tick_cnt <= 8'd0;
    end else begin
      START   <= 1'b0;
      MOVE_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (key_rise) begin
            state    <= ARMED;
            START    <= 1'b1;
            SCORE    <= 10'd0;
            LEVEL    <= 3'd0;
            tick_cnt <= 8'd0;
            OVER     <= 1'b0;
          end
        end
        ARMED: begin
          tick_cnt <= 8'd0;
          if (SQUARE_READY) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (COLLISION) begin
            // Collision beats both a score event and a tick expiry in the same cycle.
            state <= GAME_OVER;
            OVER  <= 1'b1;
          end else begin
            // >= rather than == so a period that shrinks mid-count still fires at once.
            if (tick_cnt >= period - 8'd1) begin
              MOVE_EN  <= 1'b1;
              tick_cnt <= 8'd0;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
            if (BLOCK_SHIFT) begin
              SCORE <= score_inc;
              if (score_lvl_up && (LEVEL < 3'(MAX_LEVEL))) begin
                LEVEL <= LEVEL + 3'd1;
              end
            end
          end
        end
        GAME_OVER: begin
          if (key_rise) begin
            state <= IDLE;
            OVER  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed game flow with randomized score events against a score/level/period model.
// Latency: outputs sampled 1 time unit after each rising CLK edge; inputs driven at the same point.
// Backpressure: none; every wait is bounded by a cycle guard or the watchdog.
module tb_game_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       KEY_START;
  logic       SQUARE_READY;
  logic       BLOCK_SHIFT;
  logic       COLLISION;
  logic       START;
  logic       MOVE_EN;
  logic       OVER;
  logic [9:0] SCORE;
  logic [2:0] LEVEL;
  logic [1:0] STATE;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: number of scoring events in this game and cycles since the last MOVE_EN.
  int n_shift = 0;
  int since   = 0;

  localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 3, S_OVER = 2;

  always #5 CLK = ~CLK;

  game_sequencer dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .KEY_START    (KEY_START),
    .SQUARE_READY (SQUARE_READY),
    .BLOCK_SHIFT  (BLOCK_SHIFT),
    .COLLISION    (COLLISION),
    .START        (START),
    .MOVE_EN      (MOVE_EN),
    .OVER         (OVER),
    .SCORE        (SCORE),
    .LEVEL        (LEVEL),
    .STATE        (STATE)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int exp_score(input int n);
    return (n < 999) ? n : 999;
  endfunction

  function automatic int exp_level(input int s);
    return (s / 10 > 5) ? 5 : s / 10;
  endfunction

  function automatic int period_of(input int lvl);
    return (8 - lvl < 2) ? 2 : 8 - lvl;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_start", START, 0);
    chk("rst_move", MOVE_EN, 0);
    chk("rst_over", OVER, 0);
    chk("rst_score", SCORE, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_state", STATE, S_IDLE);
  endtask

  // Release the key long enough to be seen low, press it, and check the 3-edge START timing.
  task automatic key_press(input bit expect_start, input int old_state, input int new_state);
    KEY_START = 1'b0;
    repeat (4) tick();
    KEY_START = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("key_start_pulse", START, (expect_start && k == 3) ? 1 : 0);
      chk("key_state", STATE, (k < 3) ? old_state : new_state);
    end
  endtask

  task automatic enter_run();
    repeat ($urandom_range(2, 6)) begin
      tick();
      chk("armed_state", STATE, S_ARMED);
      chk("armed_move", MOVE_EN, 0);
    end
    SQUARE_READY = 1'b1;
    tick();
    SQUARE_READY = 1'b0;
    chk("run_entry_state", STATE, S_RUN);
    since   = 0;
    n_shift = 0;
  endtask

  // One RUN cycle: drive scoring/collision inputs, advance one edge, compare with the model.
  task automatic run_cycle(input bit shift, input bit coll);
    int p;
    p = period_of(exp_level(exp_score(n_shift)));
    BLOCK_SHIFT = shift;
    COLLISION   = coll;
    tick();
    BLOCK_SHIFT = 1'b0;
    COLLISION   = 1'b0;
    if (coll) begin
      chk("coll_over", OVER, 1);
      chk("coll_state", STATE, S_OVER);
      chk("coll_move", MOVE_EN, 0);
    end else begin
      since++;
      chk("run_move", MOVE_EN, (since >= p) ? 1 : 0);
      if (since >= p) since = 0;
      if (shift) n_shift++;
      chk("run_state", STATE, S_RUN);
      chk("run_over", OVER, 0);
    end
    chk("run_score", SCORE, exp_score(n_shift));
    chk("run_level", LEVEL, exp_level(exp_score(n_shift)));
  endtask

  // GAME_OVER must ignore scoring and collision inputs and never tick.
  task automatic over_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      BLOCK_SHIFT = 1'($urandom_range(0, 1));
      COLLISION   = 1'($urandom_range(0, 1));
      tick();
      chk("over_move", MOVE_EN, 0);
      chk("over_flag", OVER, 1);
      chk("over_state", STATE, S_OVER);
      chk("over_score", SCORE, exp_score(n_shift));
      chk("over_level", LEVEL, exp_level(exp_score(n_shift)));
    end
    BLOCK_SHIFT = 1'b0;
    COLLISION   = 1'b0;
  endtask

  initial begin
    int guard;
    RESET        = 1'b1;
    KEY_START    = 1'b0;
    SQUARE_READY = 1'b0;
    BLOCK_SHIFT  = 1'b0;
    COLLISION    = 1'b0;
    repeat (2) tick();
    chk_reset_outputs();
    RESET = 1'b0;
    repeat (3) tick();
    chk("idle_state", STATE, S_IDLE);

    // First game: key press, arm, run at level 0.
    key_press(1'b1, S_IDLE, S_ARMED);
    chk("arm_score", SCORE, 0);
    chk("arm_over", OVER, 0);
    chk("arm_level", LEVEL, 0);
    enter_run();
    repeat (40) run_cycle(1'b0, 1'b0);

    guard = 0;
    while (n_shift < 10 && guard < 5000) begin
      run_cycle($urandom_range(0, 99) < 30, 1'b0);
      guard++;
    end
    chk("reach_10", n_shift, 10);
    repeat (30) run_cycle(1'b0, 1'b0);

    guard = 0;
    while (n_shift < 70 && guard < 5000) begin
      run_cycle($urandom_range(0, 99) < 50, 1'b0);
      guard++;
    end
    chk("reach_70", n_shift, 70);
    repeat (30) run_cycle(1'b0, 1'b0);

    guard = 0;
    while (n_shift < 1000 && guard < 5000) begin
      run_cycle($urandom_range(0, 99) < 90, 1'b0);
      guard++;
    end
    chk("sat_score", SCORE, 999);
    chk("sat_level", LEVEL, 5);
    repeat (10) run_cycle(1'b0, 1'b0);

    run_cycle(1'b0, 1'b1);
    over_hold(12);

    // Restart: first press returns to IDLE holding the score, second press clears it.
    key_press(1'b0, S_OVER, S_IDLE);
    chk("idle_over", OVER, 0);
    chk("idle_score_held", SCORE, 999);
    chk("idle_level_held", LEVEL, 5);
    for (int i = 0; i < 5; i++) begin
      BLOCK_SHIFT = 1'($urandom_range(0, 1));
      COLLISION   = 1'($urandom_range(0, 1));
      tick();
      chk("idle_ignore_state", STATE, S_IDLE);
      chk("idle_ignore_score", SCORE, 999);
    end
    BLOCK_SHIFT = 1'b0;
    COLLISION   = 1'b0;
    key_press(1'b1, S_IDLE, S_ARMED);
    chk("rearm_score", SCORE, 0);
    chk("rearm_level", LEVEL, 0);

    // Second game: collision coincides with a score event and a tick expiry at score 9.
    enter_run();
    guard = 0;
    while (n_shift < 9 && guard < 5000) begin
      run_cycle($urandom_range(0, 99) < 40, 1'b0);
      guard++;
    end
    guard = 0;
    while (since != period_of(0) - 1 && guard < 20) begin
      run_cycle(1'b0, 1'b0);
      guard++;
    end
    chk("align_tick", since, period_of(0) - 1);
    run_cycle(1'b1, 1'b1);
    chk("coll9_score", SCORE, 9);
    chk("coll9_level", LEVEL, 0);
    over_hold(20);

    // Third game, then an asynchronous reset between clock edges with the key held.
    key_press(1'b0, S_OVER, S_IDLE);
    key_press(1'b1, S_IDLE, S_ARMED);
    enter_run();
    repeat (25) run_cycle($urandom_range(0, 99) < 50, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    chk_reset_outputs();
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_key_start", START, 0);
      chk("held_key_state", STATE, S_IDLE);
    end
    key_press(1'b1, S_IDLE, S_ARMED);
    chk("post_rst_score", SCORE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller that sequences the obstacle datapath. It turns the player's start key into a one-cycle START pulse. It then waits for the square to report ready and paces obstacle movement with a level-dependent MOVE_EN tick. It also counts obstacles cleared into a score, raises the level, and latches OVER on collision. It sits between the key/collision logic and the obstacle controller, on the same 100 Hz game clock.

## Interface
- BASE_PERIOD, 8: MOVE_EN period in CLK cycles at level 0; range 2..255.
- PERIOD_STEP, 1: period reduction per level.
- MIN_PERIOD, 2: floor on the period; at least 1.
- LEVEL_STEP, 10: score points per level-up.
- MAX_LEVEL, 5: level saturation value; at most 7.
- SCORE_MAX, 999: score saturation value.
- CLK, input, 1: game clock (100 Hz).
- RESET, input, 1: reset, asynchronous and active-high.
- KEY_START, input, 1: raw start/restart key, asynchronous level.
- SQUARE_READY, input, 1: square is in position (level).
- BLOCK_SHIFT, input, 1: one-cycle pulse when the leading obstacle leaves the screen.
- COLLISION, input, 1: square/obstacle overlap (level).
- START, output, 1: one-cycle pulse that launches the obstacle controller.
- MOVE_EN, output, 1: one-cycle tick; the obstacle controller advances only when this is high.
- OVER, output, 1: game over (level).
- SCORE, output, 10: obstacles cleared, binary, saturating.
- LEVEL, output, 3: current difficulty.
- STATE, output, 2: current state, for display.

## Operation
- KEY_START passes through two synchronizer flops, then a previous-value flop. key_rise = sync2 & ~prev.
- States and encodings:
  - IDLE = 00
  - ARMED = 01
  - RUN = 11
  - GAME_OVER = 10
- IDLE -> ARMED on key_rise:
  - START = 1 for exactly that transition cycle.
  - SCORE, LEVEL and the tick counter clear to 0.
  - OVER clears to 0.
- ARMED -> RUN when SQUARE_READY = 1. The tick counter is held at 0 while in ARMED. key_rise is ignored.
- RUN:
  - The tick counter increments every cycle.
  - period = max(BASE_PERIOD - LEVEL*PERIOD_STEP, MIN_PERIOD), computed at 8 bits with no underflow. If the subtraction would go negative, the result is MIN_PERIOD.
  - When counter >= period-1: MOVE_EN is registered to 1 and the counter returns to 0. The >= covers a period shrink mid-count.
- BLOCK_SHIFT in RUN:
  - SCORE increments by 1 and saturates at SCORE_MAX.
  - If the new SCORE is a nonzero multiple of LEVEL_STEP, LEVEL increments by 1, saturating at MAX_LEVEL.
  - The new period applies from the next cycle.
- RUN -> GAME_OVER when COLLISION = 1:
  - OVER goes to 1 and MOVE_EN is forced to 0.
  - SCORE and LEVEL freeze.
- Simultaneous COLLISION and BLOCK_SHIFT: collision wins and SCORE is not incremented.
- Simultaneous COLLISION and tick expiry: MOVE_EN stays 0.
- GAME_OVER -> IDLE on key_rise:
  - OVER clears to 0.
  - SCORE and LEVEL are held until the next IDLE -> ARMED transition.
- BLOCK_SHIFT and COLLISION are ignored outside RUN.
- An illegal STATE value recovers to IDLE on the next clock edge.

## Timing
- On RESET assertion, all outputs go to their reset values immediately (asynchronous):
  - START, MOVE_EN, OVER = 0
  - SCORE, LEVEL = 0
  - STATE = IDLE
  - synchronizer and tick counter = 0
- All outputs are registered; there is no combinational input-to-output path.
- KEY_START rising before edge N gives START = 1 and STATE = ARMED after edge N+2. START drops after edge N+3.
- SQUARE_READY high at edge E gives STATE = RUN after E. The first MOVE_EN is high after edge E+period and is one cycle wide. Later pulses are spaced exactly period cycles apart while LEVEL is constant.
- BLOCK_SHIFT high at edge E gives the SCORE (and LEVEL) update visible after E.
- COLLISION high at edge E gives OVER = 1 and STATE = GAME_OVER after E. No MOVE_EN is produced after E.
- RESET released mid-RUN: the block restarts in IDLE and requires a fresh key press.

## Test plan
- Reset then key press (KEY_START 0->1 held): START is a single pulse 3 edges later, STATE = 01, SCORE = 0, OVER = 0.
- ARMED, SQUARE_READY = 1 at level 0 with defaults: MOVE_EN pulses every 8 cycles, first pulse 8 cycles after entering RUN.
- 10 BLOCK_SHIFT pulses: SCORE = 10, LEVEL = 1, MOVE_EN spacing becomes 7. After 70 pulses: LEVEL = 5, spacing 3. After 1000 pulses: SCORE = 999, LEVEL = 5.
- COLLISION and BLOCK_SHIFT asserted in the same cycle at SCORE = 9: OVER = 1, SCORE stays 9, LEVEL stays 0, no further MOVE_EN.
- GAME_OVER, key press: STATE = IDLE with OVER = 0 and SCORE held. Second key press: SCORE = 0, LEVEL = 0, START pulse.
- RESET pulsed mid-RUN between clock edges: all outputs reach their reset values before the next edge. Key held high through reset release produces no START until it is released and pressed again.
